// File: rtl/div_radix2_if.sv
// div_radix2_if -- request/result bundle between the ALU and the radix-2 divider.
//
// Signals:
//   alucontrol  [7:0]         operation code (signed DIV vs unsigned DIVU)
//   opdata1_i   [DATA_W-1:0]  dividend
//   opdata2_i   [DATA_W-1:0]  divisor
//   start_i                   division request, held by the ALU until ready_o
//   annul_i                   cancel an in-flight division
//   result_o    [2*DATA_W-1:0] {remainder, quotient}
//   ready_o                   result valid
//
// Modports: master = ALU side (drives request), slave = divider side.
interface div_radix2_if #(
  parameter int DATA_W = 32
);
  logic [7:0]          alucontrol;
  logic [DATA_W-1:0]   opdata1_i;
  logic [DATA_W-1:0]   opdata2_i;
  logic                start_i;
  logic                annul_i;
  logic [2*DATA_W-1:0] result_o;
  logic                ready_o;

  modport master (
    output alucontrol, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  alucontrol, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_radix2.sv
// div_radix2 -- iterative radix-2 restoring divider for the EXE-stage DIV/DIVU.
//
// One quotient bit per clock. A request is accepted in FREE, the operands are
// reduced to magnitudes (signed ops), 32 restoring steps run in ON, the sign is
// fixed on the last step and {remainder, quotient} is held in END until the ALU
// drops start_i. A zero divisor skips the iteration and returns 0.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   div_radix2_if.slave (alucontrol, opdata1_i, opdata2_i, start_i,
//         annul_i in; result_o, ready_o out -- both registered)
module div_radix2 #(
  parameter int          DATA_W     = 32,
  parameter logic [7:0]  EXE_DIV_OP = 8'b0001_1010  // any other code divides unsigned
) (
  input  logic          clk,
  input  logic          rst,
  div_radix2_if.slave   bus
);

  localparam int                CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  // Holds the dividend magnitude; quotient bits shift in from the LSB as the
  // dividend bits shift out of the MSB, so one register serves both.
  logic [DATA_W-1:0]     dividend_q;
  logic [DATA_W-1:0]     divisor_q;
  logic [DATA_W-1:0]     rem_q;
  logic                  neg_quo_q;
  logic                  neg_rem_q;
  logic [2*DATA_W-1:0]   result_q;
  logic                  ready_q;

  logic                  is_signed_s;
  logic [DATA_W-1:0]     mag1_s;
  logic [DATA_W-1:0]     mag2_s;
  logic [DATA_W:0]       trial_s;
  logic [DATA_W-1:0]     rem_d;
  logic [DATA_W-1:0]     quo_d;
  logic [DATA_W-1:0]     quo_fix_s;
  logic [DATA_W-1:0]     rem_fix_s;

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

  // Operand magnitudes at acceptance and one restoring step of the datapath.
  always_comb begin
    is_signed_s = (bus.alucontrol == EXE_DIV_OP);
    mag1_s      = (is_signed_s && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
    mag2_s      = (is_signed_s && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;

    // 33-bit trial: partial remainder can reach 2*divisor-1 after the shift.
    trial_s = {rem_q, dividend_q[DATA_W-1]} - {1'b0, divisor_q};
    if (!trial_s[DATA_W]) begin
      rem_d = trial_s[DATA_W-1:0];
      quo_d = {dividend_q[DATA_W-2:0], 1'b1};
    end else begin
      rem_d = {rem_q[DATA_W-2:0], dividend_q[DATA_W-1]};
      quo_d = {dividend_q[DATA_W-2:0], 1'b0};
    end

    quo_fix_s = neg_quo_q ? -quo_d : quo_d;
    rem_fix_s = neg_rem_q ? -rem_d : rem_d;
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FREE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        S_FREE: begin
          ready_q  <= 1'b0;
          result_q <= '0;
          if (bus.start_i && !bus.annul_i) begin
            neg_quo_q  <= is_signed_s && (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
            neg_rem_q  <= is_signed_s && bus.opdata1_i[DATA_W-1];
            dividend_q <= mag1_s;
            divisor_q  <= mag2_s;
            rem_q      <= '0;
            cnt_q      <= '0;
            state_q    <= (bus.opdata2_i == '0) ? S_BYZERO : S_ON;
          end else begin
            state_q <= S_FREE;
          end
        end

        S_ON: begin
          if (bus.annul_i) begin
            cnt_q   <= '0;
            state_q <= S_FREE;
          end else begin
            rem_q      <= rem_d;
            dividend_q <= quo_d;
            if (cnt_q == LAST) begin
              result_q <= {rem_fix_s, quo_fix_s};
              ready_q  <= 1'b1;
              cnt_q    <= '0;
              state_q  <= S_END;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end

        // Two cycles in BYZERO so the zero result appears on the second edge
        // after acceptance; cnt_q marks the first of those cycles.
        S_BYZERO: begin
          if (bus.annul_i) begin
            cnt_q   <= '0;
            state_q <= S_FREE;
          end else if (cnt_q == '0) begin
            cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b1;
            state_q  <= S_END;
          end
        end

        // Result is committed here, so annul_i has no effect.
        S_END: begin
          if (!bus.start_i) begin
            ready_q  <= 1'b0;
            result_q <= '0;
            state_q  <= S_FREE;
          end else begin
            state_q <= S_END;
          end
        end

        default: begin
          cnt_q    <= '0;
          ready_q  <= 1'b0;
          result_q <= '0;
          state_q  <= S_FREE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_radix2.sv
// tb_div_radix2 -- self-checking bench for div_radix2 (directed, random,
// divide-by-zero, annul, reset mid-operation, back-to-back).
module tb_div_radix2;

  localparam logic [7:0] DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] DIVU_OP = 8'b0001_1011;
  localparam int         LAT_NZ  = 33;  // edges from driving start to ready (E0..E32)
  localparam int         LAT_Z   = 3;   // E0..E2 for a zero divisor

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  div_radix2_if #(.DATA_W(32)) bus ();

  div_radix2 #(.DATA_W(32), .EXE_DIV_OP(DIV_OP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic, truncating division.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Called at posedge+1; drives a request and waits (bounded) for ready_o.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input bit scramble, output logic [63:0] res, output int lat);
    bus.alucontrol = sgn ? DIV_OP : DIVU_OP;
    bus.opdata1_i  = a;
    bus.opdata2_i  = b;
    bus.start_i    = 1'b1;
    bus.annul_i    = 1'b0;
    lat = -1;
    res = 64'd0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (scramble) begin
        bus.opdata1_i  = $urandom;
        bus.opdata2_i  = $urandom;
        bus.alucontrol = 8'($urandom_range(0, 255));
      end
      if (bus.ready_o) begin
        lat = c;
        res = bus.result_o;
        break;
      end
    end
  endtask

  // Holds start one more edge (optionally pulsing annul), then drops it.
  task automatic finish_div(input bit annul_end, output logic rdy_hold, output logic [63:0] res_hold,
                            output logic rdy_drop, output logic [63:0] res_drop);
    bus.annul_i = annul_end;
    @(posedge clk); #1;
    rdy_hold    = bus.ready_o;
    res_hold    = bus.result_o;
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    rdy_drop = bus.ready_o;
    res_drop = bus.result_o;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start_i = 1'b0; bus.annul_i = 1'b0;
    bus.alucontrol = 8'd0; bus.opdata1_i = 32'd0; bus.opdata2_i = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.ready_o); end
    checks++;
    if (bus.result_o !== 64'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", bus.result_o); end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b expected 0", bus.ready_o); end
  endtask

  task automatic test_directed;
    logic        sgn_t [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] a_t   [7] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFFF, 32'd5, 32'd1234};
    logic [31:0] b_t   [7] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1, 32'd9, 32'd0};
    logic [63:0] e_t   [7] = '{64'h00000002_0000000E, 64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD,
                               64'h00000000_80000000, 64'h00000000_FFFFFFFF, 64'h00000005_00000000,
                               64'h0};
    logic [63:0] res, res_hold, res_drop;
    logic        rdy_hold, rdy_drop;
    int          lat, exp_lat;
    for (int i = 0; i < 7; i++) begin
      exp_lat = (b_t[i] == 32'd0) ? LAT_Z : LAT_NZ;
      run_div(sgn_t[i], a_t[i], b_t[i], 1'b0, res, lat);
      finish_div(i[0], rdy_hold, res_hold, rdy_drop, res_drop);
      checks++;
      if (lat !== exp_lat) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, exp_lat); end
      checks++;
      if (res !== e_t[i]) begin errors++; $display("FAIL dir%0d_result: got %h expected %h", i, res, e_t[i]); end
      checks++;
      if (rdy_hold !== 1'b1 || res_hold !== e_t[i]) begin
        errors++; $display("FAIL dir%0d_hold: got %b/%h expected 1/%h", i, rdy_hold, res_hold, e_t[i]);
      end
      checks++;
      if (rdy_drop !== 1'b0 || res_drop !== 64'd0) begin
        errors++; $display("FAIL dir%0d_drop: got %b/%h expected 0/0", i, rdy_drop, res_drop);
      end
    end
  endtask

  task automatic test_random;
    logic [63:0] res, exp, res_hold, res_drop;
    logic        rdy_hold, rdy_drop, sgn;
    logic [31:0] a, b;
    int          lat, exp_lat;
    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      exp     = ref_div(sgn, a, b);
      exp_lat = (b == 32'd0) ? LAT_Z : LAT_NZ;
      run_div(sgn, a, b, 1'b1, res, lat);
      finish_div(1'b0, rdy_hold, res_hold, rdy_drop, res_drop);
      checks++;
      if (lat !== exp_lat || res !== exp) begin
        errors++;
        $display("FAIL rand%0d: op=%b a=%h b=%h got lat %0d res %h expected lat %0d res %h",
                 i, sgn, a, b, lat, res, exp_lat, exp);
      end
      checks++;
      if (rdy_drop !== 1'b0) begin errors++; $display("FAIL rand%0d_drop: got %b expected 0", i, rdy_drop); end
    end
  endtask

  task automatic test_annul;
    logic [63:0] res, res_hold, res_drop;
    logic        rdy_hold, rdy_drop, seen;
    int          lat;
    bus.alucontrol = DIVU_OP; bus.opdata1_i = 32'd1000; bus.opdata2_i = 32'd3;
    bus.start_i = 1'b1;
    repeat (11) @(posedge clk);  // acceptance edge plus ten steps
    #1;
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.ready_o) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL annul_no_ready: got %b expected 0", seen); end
    run_div(1'b0, 32'd9, 32'd3, 1'b0, res, lat);
    finish_div(1'b0, rdy_hold, res_hold, rdy_drop, res_drop);
    checks++;
    if (lat !== LAT_NZ || res !== 64'h00000000_00000003) begin
      errors++; $display("FAIL annul_next: got lat %0d res %h expected lat %0d res 3", lat, res, LAT_NZ);
    end
  endtask

  task automatic test_rst_mid;
    logic [63:0] res, exp, res_hold, res_drop;
    logic        rdy_hold, rdy_drop, seen;
    int          lat;
    bus.alucontrol = DIV_OP; bus.opdata1_i = 32'hFFFFFF9C; bus.opdata2_i = 32'd7;
    bus.start_i = 1'b1;
    repeat (21) @(posedge clk);  // acceptance edge plus twenty steps
    #2;
    bus.opdata1_i = 32'd55;      // mid-op change must not matter
    rst = 1'b1;
    bus.start_i = 1'b0;
    #1;
    checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      errors++; $display("FAIL rst_mid_on: got %b/%h expected 0/0", bus.ready_o, bus.result_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.ready_o) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_ready: got %b expected 0", seen); end

    // Reset while the result is being held: ready must drop without an edge.
    exp = ref_div(1'b1, 32'hFFFFFF9C, 32'd7);
    run_div(1'b1, 32'hFFFFFF9C, 32'd7, 1'b1, res, lat);
    checks++;
    if (lat !== LAT_NZ || res !== exp) begin
      errors++; $display("FAIL rst_pre_div: got lat %0d res %h expected lat %0d res %h", lat, res, LAT_NZ, exp);
    end
    #2;
    rst = 1'b1;
    bus.start_i = 1'b0;
    #1;
    checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      errors++; $display("FAIL rst_in_end: got %b/%h expected 0/0", bus.ready_o, bus.result_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run_div(1'b0, 32'd77, 32'd10, 1'b0, res, lat);
    finish_div(1'b0, rdy_hold, res_hold, rdy_drop, res_drop);
    checks++;
    if (lat !== LAT_NZ || res !== 64'h00000007_00000007) begin
      errors++; $display("FAIL rst_after: got lat %0d res %h expected lat %0d res 00000007_00000007", lat, res, LAT_NZ);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] res, exp, res_hold, res_drop;
    logic        rdy_hold, rdy_drop;
    logic [31:0] a, b;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      a   = $urandom;
      b   = 32'($urandom_range(1, 1000));
      exp = ref_div(1'b1, a, b);
      run_div(1'b1, a, b, 1'b0, res, lat);
      finish_div(1'b0, rdy_hold, res_hold, rdy_drop, res_drop);
      checks++;
      if (lat !== LAT_NZ || res !== exp) begin
        errors++; $display("FAIL b2b%0d: got lat %0d res %h expected lat %0d res %h", i, lat, res, LAT_NZ, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_annul();
    test_rst_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_radix2.md
# div_radix2

Iterative radix-2 restoring divider serving the ALU's DIV/DIVU operations in the EXE stage; the ALU instantiates it and drives its start/operands. Produces a 64-bit {remainder, quotient} word that the ALU forwards unchanged as its HI/LO update (HI = remainder, LO = quotient). Multi-cycle with a start/ready handshake so the pipeline can stall EXE until the result is valid.

## Interface
- DATA_W, 32, operand width; result is 2*DATA_W. Only 32 is required to be supported.
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- alucontrol  in  8  operation code; `EXE_DIV_OP = signed, `EXE_DIVU_OP = unsigned (defines.vh); sampled only when a division is accepted
- opdata1_i  in  32  dividend; sampled only at acceptance
- opdata2_i  in  32  divisor; sampled only at acceptance
- start_i  in  1  request; ALU holds it high while op is DIV/DIVU and ready_o is low
- annul_i  in  1  cancel in-flight division (exception/flush)
- result_o  out  64  {remainder[31:0], quotient[31:0]}, registered
- ready_o  out  1  result valid, registered

## Operation
- FSM states: FREE, BYZERO, ON, END. Reset state FREE.
- FREE: if start_i=1 and annul_i=0 → accept: latch signed flag (alucontrol==`EXE_DIV_OP) and operand signs; if opdata2_i==0 → BYZERO, else → ON. Otherwise stay; ready_o=0, result_o=0.
- Load (signed only): negative operands replaced by two's-complement magnitude. 0x80000000 magnitude is 2^31, valid as unsigned 32-bit.
- ON: one restoring step per cycle, counter 0..31. Partial remainder shifted left with next dividend bit; 33-bit trial subtract of divisor; non-negative → keep difference, quotient bit 1; else restore, bit 0.
- On step 31 (counter==31): apply sign fix, register result_o, set ready_o=1, → END.
- Sign fix (signed only): quotient negated if dividend sign ≠ divisor sign; remainder negated if dividend negative. Unsigned: no fix.
- BYZERO: next cycle → END with result_o=64'h0, ready_o=1. No trap raised (MIPS: undefined result).
- END: hold result_o and ready_o=1 while start_i=1. When start_i=0 → FREE, ready_o=0, result_o=0.
- annul_i=1 in ON or BYZERO → FREE next edge, ready_o stays 0, no result. annul_i in END is ignored (result already committed). annul_i in FREE blocks acceptance.
- Operands and alucontrol are don't-care after acceptance; changes mid-operation have no effect.

## Timing
- Reset (async, any state): state=FREE, counter=0, result_o=64'h0, ready_o=0, internal registers 0.
- Edge E0: start sampled in FREE. Non-zero divisor: edges E1..E32 perform 32 steps; ready_o and result_o valid after E32 (32 cycles after acceptance edge).
- Divide by zero: valid after E2.
- ready_o stays high until the first edge where start_i=0 in END; it falls on that edge. Minimum high time 1 cycle.
- Back-to-back: a new division can be accepted no earlier than the edge after returning to FREE.
- Reset asserted mid-ON: outputs zero immediately (async), no partial result ever presented.
- ready_o never asserts without a preceding accepted start.

## Test plan
- DIVU 100/7: start held high → after 32 cycles ready_o=1, result_o=64'h00000002_0000000E; drop start → next edge ready_o=0, result_o=0.
- DIV -7/2 (0xFFFFFFF9/0x00000002) → result_o=64'hFFFFFFFF_FFFFFFFD; DIV 7/-2 → 64'h00000001_FFFFFFFD.
- Boundaries: DIV 0x80000000/0xFFFFFFFF → 64'h00000000_80000000; DIVU 0xFFFFFFFF/1 → 64'h00000000_FFFFFFFF; DIVU 5/9 → 64'h00000005_00000000.
- Divide by zero: DIV 1234/0 → ready_o=1 two cycles after acceptance, result_o=0.
- annul_i pulsed at step 10 → FSM to FREE, ready_o never rises; following DIVU 9/3 completes correctly → 64'h00000000_00000003.
- rst asserted at step 20 (between edges) → ready_o and result_o 0 immediately; after release, no ready until a new start; operand change mid-ON does not alter result.
